vio_bus_sched: RTL

//  Schedules a shared bidirectional bus (bus_io, default 4 bits, like vio[0:3]) among NREQ requesters.
//  - Round-robin arbitration between requesters.
//  - Inserts turnaround cycles whenever the bus direction changes.
//  - Limits each grant to MAX_BEATS beats.
//  - Owns the tri-state enable, so no requester ever drives the pad directly.

---
 rtl/vio_bus_pkg.sv | 19 +
 rtl/vio_rr_pick.sv | 28 ++
 rtl/vio_bus_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/vio_bus_pkg.sv
// Shared types and constants for the vio bus scheduler: FSM encodings,
// bus direction codes and an index-width helper.
package vio_bus_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t TURN = 2'd1;
    localparam state_t XFER = 2'd2;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vio_rr_pick.sv
// Round-robin picker: first set request scanning from ptr upward, with wrap.
module vio_rr_pick
    import vio_bus_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            any,
    output logic [PW-1:0]   winner
);

    always_comb begin
        int idx;
        idx    = 0;
        any    = 1'b0;
        winner = ptr;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/vio_bus_sched.sv
// Shared bidirectional bus scheduler: round-robin grants, direction-change
// turnaround, per-grant beat limit and sole ownership of the pad enable.
module vio_bus_sched
    import vio_bus_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int NREQ      = 2,
    parameter int MAX_BEATS = 4,
    parameter int TURN_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_wr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  rd_valid,
    output logic                  bus_oe,
    output logic                  busy,
    inout  wire  [WIDTH-1:0]      bus_io
);

    localparam int PW = idx_w(NREQ);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic             dir;
    logic             last_dir;
    logic [BW-1:0]    beat_cnt;
    logic [TW-1:0]    turn_cnt;

    logic             pick_any;
    logic [PW-1:0]    pick_win;
    logic             own_req;
    logic             beat;
    logic             xfer_done;
    logic [PW-1:0]    nxt_ptr;
    logic [WIDTH-1:0] wdata_sel;

    vio_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (pick_any),
        .winner (pick_win)
    );

    assign own_req   = req[owner];
    assign beat      = (state == XFER) && own_req;
    // A dropped request wins over the beat limit: that cycle is not a beat.
    assign xfer_done = (state == XFER) && (!own_req || (beat_cnt == BW'(MAX_BEATS - 1)));
    assign nxt_ptr   = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
    assign wdata_sel = req_wdata[int'(owner) * WIDTH +: WIDTH];

    always_comb begin
        gnt = '0;
        if (state == XFER) begin
            gnt[owner] = 1'b1;
        end
    end

    assign bus_oe = (state == XFER) && (dir == DIR_WR);
    assign busy   = (state != IDLE);
    assign bus_io = bus_oe ? wdata_sel : {WIDTH{1'bz}};

    // Arbitration, turnaround and beat accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            dir      <= DIR_RD;
            last_dir <= DIR_RD;
            beat_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner    <= pick_win;
                        dir      <= req_wr[pick_win];
                        turn_cnt <= '0;
                        state    <= (req_wr[pick_win] != last_dir) ? TURN : XFER;
                    end
                end
                TURN: begin
                    if (turn_cnt == TW'(TURN_CYC - 1)) begin
                        state    <= XFER;
                        last_dir <= dir;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (xfer_done) begin
                        state    <= IDLE;
                        ptr      <= nxt_ptr;
                        beat_cnt <= '0;
                    end else if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read capture: bus value at the beat edge, valid one cycle later
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= beat && (dir == DIR_RD);
            if (beat && (dir == DIR_RD)) begin
                rd_data <= bus_io;
            end
        end
    end

endmodule
